mux_and_sum: RTL and testbench

//  - Datapath step of the shift-add sequential multiplier: one partial-product accumulation per iteration.
//  - Controller presents the running product, the shifted multiplicand, the shifted multiplier and the iteration count.
//  - Block registers the selected sum: hold / add / subtract (two's-complement sign-bit correction).
//  - Sits between the multiplicand/multiplier shift registers and the product register of the multiplier top.

---
 rtl/mux_and_sum_if.sv | 34 +++
 rtl/mux_and_sum.sv | 51 +++++
 tb/tb_mux_and_sum.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mux_and_sum_if.sv
`default_nettype none
//============================================================================
// Module      : mux_and_sum_if
// Description : Controller-to-datapath bundle for one shift-add multiplier
//               accumulation step. The master drives the operands and the
//               enable. The slave returns the registered partial product.
// Revision    : 1.0 - initial release
//============================================================================
interface mux_and_sum_if #(
    parameter int WORD_LENGTH = 8
);
    logic                       enable;
    logic [2*WORD_LENGTH-1:0]   Product_Input;
    logic [2*WORD_LENGTH-1:0]   Multiplicand_Input;
    logic [WORD_LENGTH-1:0]     Multiplier_Input;
    logic                       Shift_CA2;
    logic [WORD_LENGTH-1:0]     counter;
    logic [2*WORD_LENGTH-1:0]   Product_Output;

    // Controller side: presents the operands and reads back the product
    modport master (
        output enable, Product_Input, Multiplicand_Input, Multiplier_Input,
               Shift_CA2, counter,
        input  Product_Output
    );

    // Datapath side: samples the operands and returns the product
    modport slave (
        input  enable, Product_Input, Multiplicand_Input, Multiplier_Input,
               Shift_CA2, counter,
        output Product_Output
    );
endinterface
`default_nettype wire

// File: rtl/mux_and_sum.sv
`default_nettype none
//============================================================================
// Module      : mux_and_sum
// Description : Performs one accumulation step of the shift-add multiplier.
//               The block selects hold, add or subtract on the running
//               partial product. The subtract path is the two's-complement
//               correction for the multiplier sign bit. The selected sum is
//               registered.
// Revision    : 1.0 - initial release
//============================================================================
module mux_and_sum #(
    parameter int WORD_LENGTH = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mux_and_sum_if.slave     bus
);

    localparam int c_LAST_INT = WORD_LENGTH - 1;
    // Index of the multiplier sign-bit iteration. The compare is made over
    // the full counter width, so out-of-range counts take the add path.
    localparam logic [WORD_LENGTH-1:0] c_LAST_COUNT = c_LAST_INT[WORD_LENGTH-1:0];

    logic [2*WORD_LENGTH-1:0] w_next;
    logic [2*WORD_LENGTH-1:0] r_product;

    // Select pass-through, add, or sign-bit subtract (modulo 2^(2W), silent wrap)
    always_comb begin
        w_next = bus.Product_Input;
        if (bus.Multiplier_Input[0]) begin
            if (bus.Shift_CA2 && (bus.counter == c_LAST_COUNT)) begin
                w_next = bus.Product_Input - bus.Multiplicand_Input;
            end else begin
                w_next = bus.Product_Input + bus.Multiplicand_Input;
            end
        end
    end

    // Register the selected result. Reset has priority and enable=0 holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_product <= '0;
        end else if (bus.enable) begin
            r_product <= w_next;
        end
    end

    assign bus.Product_Output = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mux_and_sum.sv
`default_nettype none
//============================================================================
// Module      : tb_mux_and_sum
// Description : Directed self-checking bench for mux_and_sum (W = 8).
// Revision    : 1.0 - initial release
//============================================================================
module tb_mux_and_sum;

    localparam int c_W = 8;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_and_sum_if #(.WORD_LENGTH(c_W)) bus ();

    mux_and_sum #(.WORD_LENGTH(c_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Hand-computed reference sequences
    logic [7:0]  c_mseq_m5x_m7 [8] = '{8'hF9, 8'hFC, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [15:0] c_exp_m5x_m7  [8] = '{16'hFFFB, 16'hFFFB, 16'hFFFB, 16'hFFD3,
                                       16'hFF83, 16'hFEE3, 16'hFDA3, 16'h0023};
    logic [7:0]  c_mseq_128x_m128 [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    logic [7:0]  c_mseq_2x10 [4] = '{8'd10, 8'd5, 8'd2, 8'd1};
    logic [15:0] c_mc_2x10   [4] = '{16'd2, 16'd4, 16'd8, 16'd16};
    logic [15:0] c_exp_2x10  [4] = '{16'd0, 16'd4, 16'd4, 16'd20};

    // Apply one set of inputs, then sample 1 time unit after the rising edge
    task automatic step(input logic en, input logic [15:0] p, input logic [15:0] mc,
                        input logic [7:0] mp, input logic ca2, input logic [7:0] cnt);
        bus.enable             = en;
        bus.Product_Input      = p;
        bus.Multiplicand_Input = mc;
        bus.Multiplier_Input   = mp;
        bus.Shift_CA2          = ca2;
        bus.counter            = cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        total++;
        assert (bus.Product_Output === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, bus.Product_Output, exp);
        end
    endtask

    initial begin
        logic [15:0] p;

        // Reset clears the output
        reset = 1'b1;
        step(1'b0, 16'h0, 16'h0, 8'h0, 1'b0, 8'h0);
        check("reset", 16'h0000);

        // Disabled edges ignore changing inputs
        reset = 1'b0;
        step(1'b0, 16'h1234, 16'h0101, 8'h01, 1'b0, 8'h00);
        check("hold_after_reset_a", 16'h0000);
        step(1'b0, 16'h5555, 16'h00FF, 8'hFF, 1'b1, 8'h07);
        check("hold_after_reset_b", 16'h0000);

        // -128 x 128, unsigned multiplier path
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 16'h0000, 16'hFF80 << k, 8'h80 >> k, 1'b0, 8'(k));
            check($sformatf("m128x128_k%0d", k), (k == 7) ? 16'hC000 : 16'h0000);
        end

        // -5 x -7, signed multiplier, product fed back
        p = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, p, 16'hFFFB << k, c_mseq_m5x_m7[k], 1'b1, 8'(k));
            check($sformatf("m5xm7_k%0d", k), c_exp_m5x_m7[k]);
            p = c_exp_m5x_m7[k];
        end

        // 128 x -128, signed multiplier, sign-bit subtract only at k=7
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 16'h0000, 16'h0080 << k, c_mseq_128x_m128[k], 1'b1, 8'(k));
            check($sformatf("128xm128_k%0d", k), (k == 7) ? 16'hC000 : 16'h0000);
        end

        // 2 x 10, product fed back
        p = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, p, c_mc_2x10[k], c_mseq_2x10[k], 1'b0, 8'(k));
            check($sformatf("2x10_k%0d", k), c_exp_2x10[k]);
            p = c_exp_2x10[k];
        end

        // Hold with a nonzero value while the inputs change
        step(1'b0, 16'h0100, 16'h0003, 8'h01, 1'b1, 8'h07);
        check("hold_nonzero", 16'd20);

        // Silent wrap-around
        step(1'b1, 16'h7FFF, 16'h0001, 8'h01, 1'b0, 8'h00);
        check("wrap", 16'h8000);

        // An out-of-range counter with Shift_CA2 takes the add path (full-width compare)
        step(1'b1, 16'h0010, 16'h0003, 8'h01, 1'b1, 8'h87);
        check("cnt_out_of_range", 16'h0013);
        step(1'b1, 16'h0010, 16'h0003, 8'h01, 1'b1, 8'h0F);
        check("cnt_15", 16'h0013);

        // Shift_CA2 with counter 7 subtracts
        step(1'b1, 16'h0010, 16'h0003, 8'h01, 1'b1, 8'h07);
        check("sub_k7", 16'h000D);

        // Reset has priority over enable
        reset = 1'b1;
        step(1'b1, 16'h1234, 16'h0001, 8'h01, 1'b0, 8'h00);
        check("reset_priority", 16'h0000);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
